// File: rtl/hamming_pkg.sv
// hamming_pkg: shared FSM states, SECDED flag codes and default address map
// for the sequential Hamming decoder.
package hamming_pkg;
    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, DONE
    } state_t;
    localparam logic [1:0] NOERR = 2'b00;
    localparam logic [1:0] SGL   = 2'b01;
    localparam logic [1:0] DBL   = 2'b10;
    localparam int DEF_NUM_WORDS = 15;
    localparam int DEF_SRC_BASE  = 30;
    localparam int DEF_DST_BASE  = 0;
endpackage

// File: rtl/hamming_dec_seq_if.sv
// hamming_dec_seq_if: request/done handshake plus byte-wide data-memory port.
interface hamming_dec_seq_if;
    logic       req;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    modport master (
        input  req, mem_rdata,
        output done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
    modport slave (
        output req, mem_rdata,
        input  done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/hamming_secded_dec.sv
// hamming_secded_dec: combinational SECDED(16,11) decode to {flag, 3'b000, d[11:1]}.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [15:0] word,
    output logic [15:0] result,
    output logic [1:0]  flag
);
    logic [3:0]  s;
    logic        p;
    logic [15:0] fixed;
    always_comb begin
        s = '0;
        for (int k = 1; k < 16; k++) s = word[k] ? s ^ 4'(k) : s;
        p = ^word;
        // odd overall parity means a single flip at position s (s=0 is p0 itself)
        fixed = p ? word ^ (16'd1 << s) : word;
        flag = p ? SGL : (s != 4'd0) ? DBL : NOERR;
        result = {flag, 3'b000, fixed[15:9], fixed[7:5], fixed[3]};
    end
endmodule

// File: rtl/hamming_dec_seq.sv
// hamming_dec_seq: reads NUM_WORDS encoded words from SRC_BASE, SECDED-decodes them
// and writes results to DST_BASE; HAMMING_STATS_EN adds sgl_cnt/dbl_cnt outputs.
module hamming_dec_seq
    import hamming_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int SRC_BASE  = DEF_SRC_BASE,
    parameter int DST_BASE  = DEF_DST_BASE
) (
    input logic clk,
    input logic reset,
    hamming_dec_seq_if.master bus
`ifdef HAMMING_STATS_EN
    ,
    output logic [7:0] sgl_cnt,
    output logic [7:0] dbl_cnt
`endif
);
    localparam logic [7:0] SRC  = 8'(SRC_BASE);
    localparam logic [7:0] DST  = 8'(DST_BASE);
    localparam logic [7:0] LAST = 8'(NUM_WORDS - 1);
    state_t      state, nxt;
    logic [7:0]  idx, lo, hi, src_a, dst_a;
    logic [15:0] res, dec_res;
    logic [1:0]  dec_flag;
    logic        start;

    hamming_secded_dec u_dec (.word({hi, lo}), .result(dec_res), .flag(dec_flag));

    assign start = (state == IDLE || state == DONE) && bus.req;
    assign src_a = SRC + {idx[6:0], 1'b0};
    assign dst_a = DST + {idx[6:0], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            lo    <= '0;
            hi    <= '0;
            res   <= '0;
        end else begin
            state <= nxt;
            idx   <= start ? 8'd0 : (state == WR_HI) ? idx + 8'd1 : idx;
            lo    <= (state == RD_HI) ? bus.mem_rdata : lo;
            hi    <= (state == CAP_HI) ? bus.mem_rdata : hi;
            res   <= (state == DECODE) ? dec_res : res;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = bus.req ? RD_LO : state;
            RD_LO:      nxt = RD_HI;
            RD_HI:      nxt = CAP_HI;
            CAP_HI:     nxt = DECODE;
            DECODE:     nxt = WR_LO;
            WR_LO:      nxt = WR_HI;
            WR_HI:      nxt = (idx == LAST) ? DONE : RD_LO;
            default:    nxt = IDLE;
        endcase
    end

    assign bus.done      = state == DONE;
    assign bus.mem_rd_en = state == RD_LO || state == RD_HI;
    assign bus.mem_wr_en = state == WR_LO || state == WR_HI;
    assign bus.mem_addr  = (state == RD_LO) ? src_a :
                           (state == RD_HI) ? src_a + 8'd1 :
                           (state == WR_LO) ? dst_a :
                           (state == WR_HI) ? dst_a + 8'd1 : 8'd0;
    assign bus.mem_wdata = (state == WR_LO) ? res[7:0] :
                           (state == WR_HI) ? res[15:8] : 8'd0;

`ifdef HAMMING_STATS_EN
    // counters follow the decoder during DECODE and freeze otherwise, so DONE holds them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (start) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (state == DECODE) begin
            sgl_cnt <= (dec_flag == SGL && sgl_cnt != 8'hFF) ? sgl_cnt + 8'd1 : sgl_cnt;
            dbl_cnt <= (dec_flag == DBL && dbl_cnt != 8'hFF) ? dbl_cnt + 8'd1 : dbl_cnt;
        end
    end
`else
    logic unused_flag;
    assign unused_flag = ^dec_flag;
`endif
endmodule

// File: tb/tb_hamming_dec_seq.sv
// tb_hamming_dec_seq: scoreboard bench for hamming_dec_seq with a byte memory model;
// define HAMMING_STATS_EN to also exercise the error counters.
module tb_hamming_dec_seq;
    localparam int NW = 15, SRC = 30, DST = 0, LAT = 1 + 6 * NW;
    logic clk = 0, reset = 1;
    int checks = 0, errors = 0;
    hamming_dec_seq_if bus ();
`ifdef HAMMING_STATS_EN
    logic [7:0] sgl_cnt, dbl_cnt;
`endif
    hamming_dec_seq #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef HAMMING_STATS_EN
        ,
        .sgl_cnt(sgl_cnt),
        .dbl_cnt(dbl_cnt)
`endif
    );
    always #5 clk = ~clk;

    logic [7:0]  rom [256];
    logic [7:0]  dst_mem [256];
    int          dst_tag [256];
    int          run_id = 0;
    logic [15:0] words [NW];
    logic [15:0] exp_q [$];
    logic [15:0] obs_mem [1024];
    int          obs_n = 0, rd_ptr = 0, wr_cnt = 0, overlap = 0;
    logic        have_lo = 0;
    logic [7:0]  lo_b;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= rom[bus.mem_addr];
        if (bus.mem_wr_en) begin
            dst_mem[bus.mem_addr] <= bus.mem_wdata;
            dst_tag[bus.mem_addr] <= run_id;
        end
    end

    // pairs consecutive byte writes into observed result words
    always @(negedge clk) begin
        if (bus.mem_rd_en && bus.mem_wr_en) overlap++;
        if (reset) have_lo = 0;
        else if (bus.mem_wr_en) begin
            wr_cnt++;
            if (!have_lo) begin
                lo_b = bus.mem_wdata;
                have_lo = 1;
            end else begin
                obs_mem[obs_n] = {bus.mem_wdata, lo_b};
                obs_n++;
                have_lo = 0;
            end
        end
    end

    function automatic logic [15:0] model(input logic [15:0] w);
        logic [3:0] s;
        logic p;
        logic [15:0] c;
        logic [10:0] d;
        int n;
        s = {^(w & 16'hFF00), ^(w & 16'hF0F0), ^(w & 16'hCCCC), ^(w & 16'hAAAA)};
        p = ^w;
        c = w;
        if (p) c[s] = ~c[s];
        n = 0;
        for (int k = 3; k < 16; k++)
            if (k != 4 && k != 8) begin
                d[n] = c[k];
                n++;
            end
        return {p ? 2'b01 : (s != 0) ? 2'b10 : 2'b00, 3'b000, d};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        int n;
        w = '0;
        n = 0;
        for (int k = 3; k < 16; k++)
            if (k != 4 && k != 8) begin
                w[k] = d[n];
                n++;
            end
        w[1] = ^(w & 16'hAAAA);
        w[2] = ^(w & 16'hCCCC);
        w[4] = ^(w & 16'hF0F0);
        w[8] = ^(w & 16'hFF00);
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [15:0] corrupt(input logic [15:0] w, input int n);
        int a, b;
        a = $urandom_range(0, 15);
        if (n >= 1) w[a] = ~w[a];
        if (n == 2) begin
            do b = $urandom_range(0, 15); while (b == a);
            w[b] = ~w[b];
        end
        return w;
    endfunction

    task automatic gen_words(input int maxflips);
        for (int i = 0; i < NW; i++)
            words[i] = corrupt(encode(11'($urandom)), $urandom_range(0, maxflips));
    endtask

    task automatic load();
        run_id++;
        for (int i = 0; i < NW; i++) begin
            rom[8'(SRC + 2 * i)] = words[i][7:0];
            rom[8'(SRC + 2 * i + 1)] = words[i][15:8];
            exp_q.push_back(model(words[i]));
        end
    endtask

    task automatic run(input int inj, output int lat);
        @(negedge clk);
        bus.req = 1;
        @(posedge clk);
        #1 bus.req = 0;
        lat = 1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_clear_on_start got %b exp 0", bus.done);
        end
        while (!bus.done && lat < 400) begin
            if (lat == inj) begin
                checks++;
                if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 8'(SRC + 7)}) begin
                    errors++;
                    $display("FAIL inject_point got rd=%b addr=%h exp rd=1 addr=%h",
                             bus.mem_rd_en, bus.mem_addr, 8'(SRC + 7));
                end
                bus.req = 1;
            end
            @(posedge clk);
            #1 bus.req = 0;
            lat++;
        end
    endtask

    task automatic check_results(input int n);
        logic [15:0] e, m;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_n || obs_mem[rd_ptr] !== e) begin
                errors++;
                $display("FAIL word%0d got %h exp %h (observed %0d words)", i, obs_mem[rd_ptr], e, obs_n - rd_ptr + i);
            end
            rd_ptr++;
            m = {dst_mem[8'(DST + 2 * i + 1)], dst_mem[8'(DST + 2 * i)]};
            checks++;
            if (m !== e || dst_tag[8'(DST + 2 * i)] != run_id || dst_tag[8'(DST + 2 * i + 1)] != run_id) begin
                errors++;
                $display("FAIL dst%0d got %h exp %h", i, m, e);
            end
        end
        checks++;
        if (obs_n !== rd_ptr) begin
            errors++;
            $display("FAIL word_count got %0d exp %0d", obs_n, rd_ptr);
        end
        exp_q.delete();
        rd_ptr = obs_n;
    endtask

    task automatic check_lat(input int lat);
        checks++;
        if (lat !== LAT || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL latency got %0d done=%b exp %0d done=1", lat, bus.done, LAT);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        bus.req = 0;
        #1;
        checks++;
        if ({bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got done=%b rd=%b wr=%b addr=%h wdata=%h exp all 0",
                     bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata);
        end
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.done, bus.mem_rd_en, bus.mem_wr_en} !== 3'b000) begin
            errors++;
            $display("FAIL idle_outputs got %b exp 000", {bus.done, bus.mem_rd_en, bus.mem_wr_en});
        end
    endtask

    task automatic test_no_error();
        int lat;
        gen_words(0);
        words[0] = 16'h000F;
        load();
        run(0, lat);
        check_lat(lat);
        check_results(NW);
        checks++;
        if ({dst_mem[DST + 1], dst_mem[DST]} !== 16'h0001) begin
            errors++;
            $display("FAIL no_error_bytes got %h%h exp 0001", dst_mem[DST + 1], dst_mem[DST]);
        end
    endtask

    task automatic test_single();
        int lat;
        gen_words(1);
        words[0] = 16'h002F;
        words[1] = 16'h000E;
        load();
        run(0, lat);
        check_lat(lat);
        check_results(NW);
        checks++;
        if ({dst_mem[DST + 1], dst_mem[DST]} !== 16'h4001) begin
            errors++;
            $display("FAIL single_data got %h%h exp 4001", dst_mem[DST + 1], dst_mem[DST]);
        end
        checks++;
        if ({dst_mem[DST + 3], dst_mem[DST + 2]} !== 16'h4001) begin
            errors++;
            $display("FAIL single_p0 got %h%h exp 4001", dst_mem[DST + 3], dst_mem[DST + 2]);
        end
    endtask

    task automatic test_double();
        int lat;
        gen_words(2);
        words[0] = 16'h006F;
        load();
        run(0, lat);
        check_lat(lat);
        check_results(NW);
        checks++;
        if ({dst_mem[DST + 1], dst_mem[DST]} !== 16'h8007) begin
            errors++;
            $display("FAIL double got %h%h exp 8007", dst_mem[DST + 1], dst_mem[DST]);
        end
    endtask

    task automatic test_full_run();
        int lat;
        gen_words(2);
        load();
        run(0, lat);
        check_lat(lat);
        check_results(NW);
    endtask

    task automatic test_req_ignored();
        int lat;
        gen_words(2);
        load();
        run(20, lat);
        check_lat(lat);
        check_results(NW);
    endtask

    task automatic test_reset_abort();
        int lat, base, snap, n;
        gen_words(2);
        load();
        base = wr_cnt;
        @(negedge clk);
        bus.req = 1;
        @(posedge clk);
        #1 bus.req = 0;
        n = 0;
        while (!(bus.mem_wr_en && bus.mem_addr == 8'(DST + 14)) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        #2 reset = 1;
        #1;
        checks++;
        if ({bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata} !== 19'd0) begin
            errors++;
            $display("FAIL abort_outputs got done=%b rd=%b wr=%b addr=%h wdata=%h exp all 0",
                     bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (wr_cnt - base !== 14) begin
            errors++;
            $display("FAIL abort_prior_writes got %0d exp 14", wr_cnt - base);
        end
        snap = wr_cnt;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt !== snap || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got writes=%0d done=%b exp 0 writes done=0", wr_cnt - snap, bus.done);
        end
        checks++;
        if ((dst_tag[8'(DST + 14)] == run_id) !== 1'b0) begin
            errors++;
            $display("FAIL abort_word7 got written exp untouched");
        end
        check_results(7);
        gen_words(2);
        load();
        run(0, lat);
        check_lat(lat);
        check_results(NW);
    endtask

`ifdef HAMMING_STATS_EN
    task automatic test_stats();
        int lat;
        for (int i = 0; i < NW; i++)
            words[i] = corrupt(encode(11'($urandom)), i < 4 ? 1 : i < 6 ? 2 : 0);
        load();
        run(0, lat);
        check_lat(lat);
        check_results(NW);
        checks++;
        if ({sgl_cnt, dbl_cnt} !== {8'd4, 8'd2}) begin
            errors++;
            $display("FAIL stats got sgl=%0d dbl=%0d exp sgl=4 dbl=2", sgl_cnt, dbl_cnt);
        end
    endtask
`endif

    task automatic test_no_overlap();
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL rd_wr_overlap got %0d cycles exp 0", overlap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_error();
        test_single();
        test_double();
        test_full_run();
        test_req_ignored();
        test_reset_abort();
`ifdef HAMMING_STATS_EN
        test_stats();
`endif
        test_no_overlap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_dec_seq.md
HAMMING_DEC_SEQ -- requirements
Module: hamming_dec_seq

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 15: number of 16-bit encoded words processed per request.
REQ-002 SHALL have parameter SRC_BASE, default 30: byte address of the first encoded word's low byte.
REQ-003 SHALL have parameter DST_BASE, default 0: byte address of the first result word's low byte.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 1: start request, sampled in IDLE or DONE.
REQ-007 SHALL have port done, output, 1: high while in DONE.
REQ-008 SHALL have port mem_addr, output, 8: data-memory byte address.
REQ-009 SHALL have port mem_rd_en, output, 1: read strobe; mem_rdata is valid the cycle after the strobe.
REQ-010 SHALL have port mem_rdata, input, 8: read data.
REQ-011 SHALL have ports mem_wr_en (output, 1: write strobe) and mem_wdata (output, 8: write data).

Function
REQ-012 SHALL implement FSM states IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, DONE, each lasting exactly one cycle except IDLE and DONE.
REQ-013 SHALL move IDLE->RD_LO when req=1, with word index i=0.
REQ-014 SHALL step in order: RD_LO (addr SRC_BASE+2i, rd_en=1) -> RD_HI (addr SRC_BASE+2i+1, rd_en=1, capture low byte) -> CAP_HI (capture high byte) -> DECODE (register result) -> WR_LO (addr DST_BASE+2i, wdata=result[7:0]) -> WR_HI (addr DST_BASE+2i+1, wdata=result[15:8]).
REQ-015 SHALL go WR_HI->RD_LO with i+1 when i<NUM_WORDS-1, else WR_HI->DONE; total latency from req to done = 1+6*NUM_WORDS cycles (91 at default).
REQ-016 SHALL hold done=1 in DONE until req=1, which restarts at RD_LO with i=0 and deasserts done.
REQ-017 SHALL ignore req in every state other than IDLE and DONE.
REQ-018 SHALL never assert mem_rd_en and mem_wr_en in the same cycle; both SHALL be 0 in IDLE, DECODE and DONE.
REQ-019 SHALL treat the encoded word w[15:0] as {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}, with Hamming position k = bit k.
REQ-020 SHALL compute syndrome s[3:0] as the XOR of k over all k in 1..15 with w[k]=1, and P = XOR of all 16 bits.
REQ-021 SHALL produce, for P=0 and s=0: result = {2'b00, 3'b000, d[11:1]}.
REQ-022 SHALL produce, for P=1: bit s of w inverted (s=0 means p0, data unchanged), then result = {2'b01, 3'b000, corrected d}.
REQ-023 SHALL produce, for P=0 and s!=0: result = {2'b10, 3'b000, uncorrected d}.
REQ-024 SHALL keep the 8-bit address arithmetic modulo 256 without any range check.

Reset
REQ-025 SHALL force on reset, immediately and asynchronously: state=IDLE, i=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, capture registers=0.
REQ-026 SHALL abort an in-flight run when reset is asserted; results already written stay, no further writes occur, and after release a fresh req is required.

Configuration
REQ-027 SHALL, when macro HAMMING_STATS_EN is defined, add outputs sgl_cnt[7:0] and dbl_cnt[7:0] that count single-error and double-error words in the current run, clear on run start and on reset, saturate at 255, and hold their value in DONE.
REQ-028 SHALL, when HAMMING_STATS_EN is undefined, have neither those ports nor the counters; all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state enum, the flag encodings (NOERR=2'b00, SGL=2'b01, DBL=2'b10) and the default base constants in package hamming_pkg.
REQ-030 SHALL put the purely combinational decode (REQ-019..023) in sub-module hamming_secded_dec (in: 16-bit word; out: 16-bit result, 2-bit flag), instanced once.

Verification
REQ-031 SHALL cover no error: src word 16'h000F -> dst bytes lo 8'h01, hi 8'h00.
REQ-032 SHALL cover single data error: 16'h002F (bit 5 flipped) -> lo 8'h01, hi 8'h40; repeat with p0 flipped (16'h000E) -> same 16'h4001.
REQ-033 SHALL cover double error: 16'h006F (bits 5 and 6 flipped) -> hi byte bit7=1, hi=8'h80.
REQ-034 SHALL cover a full run: 15 random words plus flips per the program-2 distribution, req pulsed one cycle -> done exactly 91 cycles later, and all 30 destination bytes match the reference model.
REQ-035 SHALL cover protocol: req during RD_HI of word 3 -> ignored; reset asserted during word 7 -> done=0 and no writes afterward; a new req -> full correct rerun.
REQ-036 SHALL cover, with HAMMING_STATS_EN: 4 single-error and 2 double-error words -> sgl_cnt=4 and dbl_cnt=2 at done.
